i2c_slv_regctl: RTL and testbench

Register-access sequencer between the I2C slave engine (`i2c_slv`) and a simple request/acknowledge register port. It implements the standard "pointer then data" protocol. The first byte of a write transaction loads the register pointer. Later written bytes are stored at the pointer, and read transactions return data from the pointer. The pointer auto-increments on every byte transferred. The block drives the slave's `rx_full`, `tx_empty` and `tx_dat` flow-control inputs, so the slave stretches SCL while a register access is pending.

---
 rtl/i2c_slv_regctl.sv | 181 ++++++++++++++++++
 tb/tb_i2c_slv_regctl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slv_regctl.sv
// i2c_slv_regctl: pointer-then-data register sequencer sitting between the
// I2C slave engine and a req/ack register port. Flow control toward the
// slave (rx_full / tx_empty) makes the slave stretch SCL while an access
// is outstanding.
module i2c_slv_regctl #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    // slave engine side
    input  logic          slv_aas,
    input  logic          slv_srw,
    input  logic          slv_nas,
    input  logic          slv_rx_wr,
    input  logic [7:0]    slv_rx_dat,
    input  logic          slv_tx_rd,
    input  logic          slv_tx_done,
    output logic          rx_full,
    output logic          tx_empty,
    output logic [7:0]    tx_dat,
    // register port
    output logic          reg_req,
    output logic          reg_we,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    input  logic          reg_ack,
    input  logic [7:0]    reg_rdata,
    // status
    output logic [AW-1:0] ptr,
    output logic          err_ovr,
    input  logic          err_clr
);

    typedef enum logic [2:0] {
        IDLE, W_PTR, W_DATA, W_BUSY, R_FETCH, R_FULL, R_END
    } state_t;

    state_t        state;
    logic          nas_d;
    logic          stop_pend;   // STOP/Sr seen while an access was in flight
    logic          nas_rise;
    logic [AW-1:0] rx_ptr;
    logic [AW-1:0] ptr_inc;

    assign nas_rise = slv_nas & ~nas_d;
    assign rx_ptr   = AW'(slv_rx_dat);
    assign ptr_inc  = ptr + AW'(1);

    // Delay flop for slv_nas edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) nas_d <= 1'b0;
        else       nas_d <= slv_nas;
    end

    // Sticky overrun flag: a byte arriving while a write is still pending
    // is dropped; setting wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                err_ovr <= 1'b0;
        else if (state == W_BUSY && slv_rx_wr)    err_ovr <= 1'b1;
        else if (err_clr)                         err_ovr <= 1'b0;
    end

    // Main sequencer; every output is registered here
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            stop_pend <= 1'b0;
            ptr       <= '0;
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            rx_full   <= 1'b0;
            tx_empty  <= 1'b1;
            tx_dat    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stop_pend <= 1'b0;
                    if (slv_aas && !nas_rise) begin
                        if (slv_srw) begin
                            state    <= R_FETCH;
                            reg_req  <= 1'b1;
                            reg_we   <= 1'b0;
                            reg_addr <= ptr;
                        end else begin
                            state <= W_PTR;
                        end
                    end
                end

                W_PTR: begin
                    // First written byte only loads the pointer
                    if (slv_rx_wr) begin
                        ptr   <= rx_ptr;
                        state <= nas_rise ? IDLE : W_DATA;
                    end else if (nas_rise) begin
                        state    <= IDLE;
                        tx_empty <= 1'b1;
                    end
                end

                W_DATA: begin
                    if (slv_rx_wr) begin
                        reg_wdata <= slv_rx_dat;
                        reg_req   <= 1'b1;
                        reg_we    <= 1'b1;
                        reg_addr  <= ptr;
                        rx_full   <= 1'b1;
                        stop_pend <= nas_rise;
                        state     <= W_BUSY;
                    end else if (nas_rise) begin
                        state    <= IDLE;
                        tx_empty <= 1'b1;
                    end
                end

                W_BUSY: begin
                    // A write handshake is never aborted; STOP is deferred
                    if (nas_rise) stop_pend <= 1'b1;
                    if (reg_ack) begin
                        reg_req <= 1'b0;
                        rx_full <= 1'b0;
                        ptr     <= ptr_inc;
                        if (stop_pend || nas_rise) begin
                            state     <= IDLE;
                            stop_pend <= 1'b0;
                            tx_empty  <= 1'b1;
                        end else begin
                            state <= W_DATA;
                        end
                    end
                end

                R_FETCH: begin
                    if (nas_rise) stop_pend <= 1'b1;
                    if (reg_ack) begin
                        reg_req <= 1'b0;
                        if (stop_pend || nas_rise) begin
                            // Fetch completed after STOP: discard the byte
                            state     <= IDLE;
                            stop_pend <= 1'b0;
                            tx_empty  <= 1'b1;
                        end else begin
                            tx_dat   <= reg_rdata;
                            tx_empty <= 1'b0;
                            state    <= R_FULL;
                        end
                    end
                end

                R_FULL: begin
                    if (nas_rise) begin
                        state    <= IDLE;
                        tx_empty <= 1'b1;
                    end else if (slv_tx_rd) begin
                        // Byte consumed: advance and prefetch the next one
                        tx_empty <= 1'b1;
                        ptr      <= ptr_inc;
                        reg_req  <= 1'b1;
                        reg_we   <= 1'b0;
                        reg_addr <= ptr_inc;
                        state    <= R_FETCH;
                    end else if (slv_tx_done) begin
                        state <= R_END;
                    end
                end

                R_END: begin
                    if (nas_rise) begin
                        state    <= IDLE;
                        tx_empty <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slv_regctl.sv
// Bench for i2c_slv_regctl: slave-engine stimulus tasks, a register-port
// responder with a byte memory, and a queue of expected register accesses.
module tb_i2c_slv_regctl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       slv_aas, slv_srw, slv_nas, slv_rx_wr, slv_tx_rd, slv_tx_done;
    logic [7:0] slv_rx_dat;
    logic       rx_full, tx_empty;
    logic [7:0] tx_dat;
    logic       reg_req, reg_we, reg_ack;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic [7:0] ptr;
    logic       err_ovr, err_clr;

    typedef struct {
        bit       we;
        bit [7:0] addr;
        bit [7:0] data;
    } acc_t;

    acc_t       exp_q[$];
    logic [7:0] mem[256];
    int         ack_dly = 1;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    i2c_slv_regctl #(.AW(8)) dut (
        .clk(clk), .rstn(rstn),
        .slv_aas(slv_aas), .slv_srw(slv_srw), .slv_nas(slv_nas),
        .slv_rx_wr(slv_rx_wr), .slv_rx_dat(slv_rx_dat),
        .slv_tx_rd(slv_tx_rd), .slv_tx_done(slv_tx_done),
        .rx_full(rx_full), .tx_empty(tx_empty), .tx_dat(tx_dat),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_ack(reg_ack), .reg_rdata(reg_rdata),
        .ptr(ptr), .err_ovr(err_ovr), .err_clr(err_clr)
    );

    // Register-port responder: acks after ack_dly cycles and checks each
    // access against the head of the expected queue.
    initial begin
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reg_req === 1'b1) begin
                acc_t first;
                first.we   = reg_we;
                first.addr = reg_addr;
                first.data = reg_wdata;
                repeat (ack_dly) @(negedge clk);
                if (reg_req === 1'b1) begin
                    tests++;
                    if (reg_we !== first.we || reg_addr !== first.addr ||
                        (reg_we && reg_wdata !== first.data)) begin
                        fails++;
                        $display("FAIL req_stable: we=%b addr=%h wd=%h, held since rise we=%b addr=%h wd=%h",
                                 reg_we, reg_addr, reg_wdata, first.we, first.addr, first.data);
                    end
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL access_unexpected: we=%b addr=%h wd=%h, no access expected",
                                 reg_we, reg_addr, reg_wdata);
                    end else begin
                        acc_t e;
                        e = exp_q.pop_front();
                        if (reg_we !== e.we || reg_addr !== e.addr || (e.we && reg_wdata !== e.data)) begin
                            fails++;
                            $display("FAIL access: got we=%b addr=%h wd=%h, expected we=%b addr=%h wd=%h",
                                     reg_we, reg_addr, reg_wdata, e.we, e.addr, e.data);
                        end
                    end
                    if (reg_we) mem[reg_addr] = reg_wdata;
                    reg_rdata = mem[reg_addr];
                    reg_ack   = 1'b1;
                    @(negedge clk);
                    reg_ack = 1'b0;
                end
            end
        end
    end

    task automatic push_acc(input bit we, input bit [7:0] addr, input bit [7:0] data);
        acc_t e;
        e.we = we; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic start_txn(input logic rw);
        @(negedge clk);
        slv_aas = 1'b1; slv_srw = rw; slv_nas = 1'b0;
    endtask

    task automatic stop_txn();
        @(negedge clk);
        slv_aas = 1'b0; slv_nas = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Wait for rx_full low, pulse one byte, count cycles rx_full stays high
    task automatic send_byte(input logic [7:0] b, output int hi);
        int n = 0;
        while (rx_full !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            tests++; fails++;
            $display("FAIL send_wait: rx_full stuck at %b, required 0", rx_full);
        end
        @(negedge clk);
        slv_rx_wr = 1'b1; slv_rx_dat = b;
        @(negedge clk);
        slv_rx_wr = 1'b0;
        hi = 0;
        while (rx_full === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
    endtask

    task automatic wait_tx_full(input string name);
        int n = 0;
        while (tx_empty !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            tests++; fails++;
            $display("FAIL %s: tx_empty stuck at %b, required 0", name, tx_empty);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        slv_aas = 0; slv_srw = 0; slv_nas = 0; slv_rx_wr = 0; slv_rx_dat = 0;
        slv_tx_rd = 0; slv_tx_done = 0; err_clr = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        repeat (3) @(negedge clk);
        tests++;
        if ({reg_req, reg_we, rx_full, tx_empty, err_ovr} !== 5'b00010) begin
            fails++;
            $display("FAIL reset_ctl: req,we,rx_full,tx_empty,err=%b, required 00010",
                     {reg_req, reg_we, rx_full, tx_empty, err_ovr});
        end
        tests++;
        if ({ptr, reg_addr, reg_wdata, tx_dat} !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: ptr,addr,wdata,tx_dat=%h, required 0",
                     {ptr, reg_addr, reg_wdata, tx_dat});
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_seq();
        int hi;
        ack_dly = 1;
        push_acc(1, 8'h10, 8'hAA);
        push_acc(1, 8'h11, 8'h55);
        start_txn(1'b0);
        send_byte(8'h10, hi);
        tests++;
        if (hi !== 0) begin fails++; $display("FAIL wr_ptr_rxfull: %0d cycles, required 0", hi); end
        send_byte(8'hAA, hi);
        tests++;
        if (hi !== 2) begin fails++; $display("FAIL wr_rxfull_1: %0d cycles, required 2", hi); end
        send_byte(8'h55, hi);
        tests++;
        if (hi !== 2) begin fails++; $display("FAIL wr_rxfull_2: %0d cycles, required 2", hi); end
        tests++;
        if (ptr !== 8'h12) begin fails++; $display("FAIL wr_ptr: %h, required 12", ptr); end
        stop_txn();
        tests++;
        if (mem[8'h10] !== 8'hAA || mem[8'h11] !== 8'h55) begin
            fails++;
            $display("FAIL wr_mem: %h %h, required aa 55", mem[8'h10], mem[8'h11]);
        end
    endtask

    task automatic test_slow_port();
        int hi;
        ack_dly = 50;
        push_acc(1, 8'h20, 8'h77);
        start_txn(1'b0);
        send_byte(8'h20, hi);
        send_byte(8'h77, hi);
        tests++;
        if (hi !== 51) begin fails++; $display("FAIL slow_rxfull: %0d cycles, required 51", hi); end
        tests++;
        if (ptr !== 8'h21 || mem[8'h20] !== 8'h77) begin
            fails++;
            $display("FAIL slow_data: ptr=%h mem=%h, required ptr=21 mem=77", ptr, mem[8'h20]);
        end
        stop_txn();
        ack_dly = 1;
    endtask

    task automatic test_read_wrap();
        int hi;
        logic [7:0] exp_b;
        ack_dly = 2;
        start_txn(1'b0);
        send_byte(8'hFE, hi);
        stop_txn();
        push_acc(0, 8'hFE, 0);
        push_acc(0, 8'hFF, 0);
        push_acc(0, 8'h00, 0);
        push_acc(0, 8'h01, 0);   // prefetch that the NAK then discards
        start_txn(1'b1);
        for (int i = 0; i < 3; i++) begin
            exp_b = mem[8'(8'hFE + i)];
            wait_tx_full("rd_wait");
            tests++;
            if (tx_dat !== exp_b) begin
                fails++;
                $display("FAIL rd_byte%0d: tx_dat=%h, required %h", i, tx_dat, exp_b);
            end
            @(negedge clk); slv_tx_rd = 1'b0;
            slv_tx_rd = 1'b1;
            @(negedge clk);
            slv_tx_rd = 1'b0;
            tests++;
            if (tx_empty !== 1'b1) begin fails++; $display("FAIL rd_empty%0d: %b, required 1", i, tx_empty); end
        end
        tests++;
        if (ptr !== 8'h01) begin fails++; $display("FAIL rd_wrap_ptr: %h, required 01", ptr); end
        wait_tx_full("rd_prefetch");
        @(negedge clk); slv_tx_done = 1'b1;
        @(negedge clk); slv_tx_done = 1'b0;
        stop_txn();
        tests++;
        if (tx_empty !== 1'b1 || ptr !== 8'h01) begin
            fails++;
            $display("FAIL rd_end: tx_empty=%b ptr=%h, required 1 01", tx_empty, ptr);
        end
    endtask

    task automatic test_overrun();
        int hi;
        int n = 0;
        ack_dly = 10;
        push_acc(1, 8'h30, 8'h11);
        start_txn(1'b0);
        send_byte(8'h30, hi);
        @(negedge clk); slv_rx_wr = 1'b1; slv_rx_dat = 8'h11;
        @(negedge clk); slv_rx_wr = 1'b0;
        @(negedge clk); slv_rx_wr = 1'b1; slv_rx_dat = 8'h99;
        @(negedge clk); slv_rx_wr = 1'b0;
        tests++;
        if (err_ovr !== 1'b1) begin fails++; $display("FAIL ovr_set: err_ovr=%b, required 1", err_ovr); end
        while (rx_full !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        tests++;
        if (mem[8'h31] !== (8'h31 ^ 8'h5A) || ptr !== 8'h31) begin
            fails++;
            $display("FAIL ovr_drop: mem31=%h ptr=%h, required %h 31", mem[8'h31], ptr, 8'h31 ^ 8'h5A);
        end
        tests++;
        if (err_ovr !== 1'b1) begin fails++; $display("FAIL ovr_sticky: err_ovr=%b, required 1", err_ovr); end
        err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        tests++;
        if (err_ovr !== 1'b0) begin fails++; $display("FAIL ovr_clr: err_ovr=%b, required 0", err_ovr); end
        stop_txn();
        ack_dly = 1;
    endtask

    task automatic test_stop_in_fetch();
        int hi;
        int n = 0;
        ack_dly = 1;
        start_txn(1'b0);
        send_byte(8'h40, hi);
        stop_txn();
        ack_dly = 10;
        push_acc(0, 8'h40, 0);
        start_txn(1'b1);
        repeat (2) @(negedge clk);
        slv_aas = 1'b0; slv_nas = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (reg_req !== 1'b1) begin fails++; $display("FAIL stop_req_held: reg_req=%b, required 1", reg_req); end
        while (reg_req !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        tests++;
        if (n >= 100) begin fails++; $display("FAIL stop_req_drop: reg_req=%b, required 0", reg_req); end
        repeat (3) @(negedge clk);
        tests++;
        if (tx_empty !== 1'b1 || ptr !== 8'h40 || reg_req !== 1'b0) begin
            fails++;
            $display("FAIL stop_fetch: tx_empty=%b ptr=%h req=%b, required 1 40 0", tx_empty, ptr, reg_req);
        end
        ack_dly = 1;
    endtask

    task automatic test_rst_mid_write();
        int hi;
        ack_dly = 50;
        start_txn(1'b0);
        send_byte(8'h50, hi);
        @(negedge clk); slv_rx_wr = 1'b1; slv_rx_dat = 8'h12;
        @(negedge clk); slv_rx_wr = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (rx_full !== 1'b1 || ptr !== 8'h50) begin
            fails++;
            $display("FAIL rst_pre: rx_full=%b ptr=%h, required 1 50", rx_full, ptr);
        end
        rstn = 1'b0;
        #1;
        tests++;
        if ({reg_req, reg_we, rx_full, tx_empty, err_ovr} !== 5'b00010 ||
            {ptr, reg_addr, reg_wdata, tx_dat} !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid: ctl=%b data=%h, required 00010 0",
                     {reg_req, reg_we, rx_full, tx_empty, err_ovr}, {ptr, reg_addr, reg_wdata, tx_dat});
        end
        slv_aas = 1'b0;
        repeat (60) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        ack_dly = 1;
    endtask

    initial begin
        test_reset();
        test_write_seq();
        test_slow_port();
        test_read_wrap();
        test_overrun();
        test_stop_in_fetch();
        test_rst_mid_write();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL acc_left: %0d expected accesses never seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
